// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache. Hits are answered combinationally;
// misses stall the PC while one whole block is fetched over a req/ack handshake.
module icache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           pc,
  output logic [31:0]                 instr,
  output logic                        mem_out_ready,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [(32<<OFFSET_BITS)-1:0] mem_rdata,
  input  logic                        mem_ack
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t                       state_r;
  logic [LINES-1:0]             valid_r;
  logic [TAG_W-1:0]             tag_arr_r [LINES];
  logic [WORDS-1:0][31:0]       data_r    [LINES];
  logic [INDEX_BITS-1:0]        fill_idx_r;
  logic [TAG_W-1:0]             fill_tag_r;

  logic [OFFSET_BITS-1:0]       word_s;
  logic [INDEX_BITS-1:0]        index_s;
  logic [TAG_W-1:0]             tag_s;
  logic                         hit_s;
  logic                         unused_s;

  assign word_s   = pc[2 +: OFFSET_BITS];
  assign index_s  = pc[OFFSET_BITS+2 +: INDEX_BITS];
  assign tag_s    = pc[ADDR_W-1 -: TAG_W];
  assign hit_s    = valid_r[index_s] && (tag_arr_r[index_s] == tag_s);
  assign unused_s = ^pc[1:0];

  // Lookup result: only IDLE answers the PC, so mem_ack traffic never leaks a word out
  always_comb begin
    mem_out_ready = 1'b0;
    instr         = 32'd0;
    if ((state_r == IDLE) && hit_s) begin
      mem_out_ready = 1'b1;
      instr         = data_r[index_s][word_s];
    end else begin
      mem_out_ready = 1'b0;
      instr         = 32'd0;
    end
  end

  // Controller FSM: miss detection, request hold, valid-bit update and the fill bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      fill_idx_r <= '0;
      fill_tag_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!hit_s) begin
            state_r    <= FETCH;
            mem_rd     <= 1'b1;
            mem_addr   <= {pc[ADDR_W-1:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
            fill_idx_r <= index_s;
            fill_tag_r <= tag_s;
          end else begin
            state_r <= IDLE;
            mem_rd  <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            state_r             <= FILL;
            mem_rd              <= 1'b0;
            valid_r[fill_idx_r] <= 1'b1;
          end else begin
            state_r <= FETCH;
            mem_rd  <= 1'b1;
          end
        end
        FILL: begin
          state_r <= IDLE;
          mem_rd  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          mem_rd  <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays need no reset; they are only written on an accepted ack
  always_ff @(posedge clk) begin
    if ((state_r == FETCH) && mem_ack) begin
      data_r[fill_idx_r]    <= mem_rdata;
      tag_arr_r[fill_idx_r] <= fill_tag_r;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl: inputs change on the falling edge,
// outputs are checked shortly after, away from the rising edge.
module tb_icache_ctrl;

  logic         clk;
  logic         rst;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         mem_out_ready;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int checks = 0;
  int errors = 0;

  logic [127:0] blk0, blk1, blk2, blk3, junk;

  icache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .instr        (instr),
    .mem_out_ready(mem_out_ready),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a missing address and follow it into the first FETCH cycle.
  task automatic expect_miss(input string nm, input logic [31:0] a, input logic [31:0] exp_addr);
    pc = a;
    #1;
    chk({nm, "_miss_rdy"}, {31'd0, mem_out_ready}, 32'd0);
    chk({nm, "_miss_instr"}, instr, 32'd0);
    chk({nm, "_miss_rd"}, {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    #1;
    chk({nm, "_fetch_rd"}, {31'd0, mem_rd}, 32'd1);
    chk({nm, "_fetch_addr"}, mem_addr, exp_addr);
    chk({nm, "_fetch_rdy"}, {31'd0, mem_out_ready}, 32'd0);
  endtask

  // Ack after 'waits' extra FETCH cycles, pass the FILL bubble, then check the replay hit.
  task automatic ack_fill(input string nm, input logic [127:0] blk, input int waits, input logic [31:0] exp_word);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      #1;
      chk({nm, "_hold_rd"}, {31'd0, mem_rd}, 32'd1);
    end
    mem_ack   = 1'b1;
    mem_rdata = blk;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    chk({nm, "_fill_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({nm, "_fill_rdy"}, {31'd0, mem_out_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk({nm, "_hit_rdy"}, {31'd0, mem_out_ready}, 32'd1);
    chk({nm, "_hit_instr"}, instr, exp_word);
  endtask

  task automatic expect_hit(input string nm, input logic [31:0] a, input logic [31:0] exp_word);
    @(negedge clk);
    pc = a;
    #1;
    chk({nm, "_rdy"}, {31'd0, mem_out_ready}, 32'd1);
    chk({nm, "_instr"}, instr, exp_word);
    chk({nm, "_rd"}, {31'd0, mem_rd}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk0 = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    blk1 = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    blk2 = {32'h8080_0003, 32'h8080_0002, 32'h8080_0001, 32'h8080_0000};
    blk3 = {32'h2020_0003, 32'h2020_0002, 32'h2020_0001, 32'h2020_0000};
    junk = {4{32'hDEAD_BEEF}};

    rst       = 1'b0;
    pc        = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdy", {31'd0, mem_out_ready}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: cold miss at 0x00, ack on the 4th FETCH cycle
    expect_miss("t1", 32'h0000_0000, 32'h0000_0000);
    ack_fill("t1", blk0, 3, 32'hD000_0000);

    // 2: remaining words of the block hit back to back
    expect_hit("t2_w1", 32'h0000_0004, 32'hD000_0001);
    expect_hit("t2_w2", 32'h0000_0008, 32'hD000_0002);
    expect_hit("t2_w3", 32'h0000_000C, 32'hD000_0003);

    // 3: index 1 miss, then a conflict on index 0 evicts the first block
    @(negedge clk);
    expect_miss("t3_i1", 32'h0000_0010, 32'h0000_0010);
    ack_fill("t3_i1", blk1, 0, 32'h1111_0000);
    @(negedge clk);
    expect_miss("t3_conf", 32'h0000_0084, 32'h0000_0080);
    ack_fill("t3_conf", blk2, 1, 32'h8080_0001);
    @(negedge clk);
    expect_miss("t3_evict", 32'h0000_0000, 32'h0000_0000);
    ack_fill("t3_evict", blk0, 0, 32'hD000_0000);
    expect_hit("t3_i1_kept", 32'h0000_0018, 32'h1111_0002);

    // 4: low pc bits are ignored
    @(negedge clk);
    expect_miss("t4", 32'h0000_0023, 32'h0000_0020);
    ack_fill("t4", blk3, 0, 32'h2020_0000);

    // 5: reset during FETCH drops mem_rd at once and a late ack is ignored
    @(negedge clk);
    expect_miss("t5", 32'h0000_0040, 32'h0000_0040);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_rd", {31'd0, mem_rd}, 32'd0);
    chk("t5_async_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    pc        = 32'h0000_0000;
    mem_ack   = 1'b1;
    mem_rdata = junk;
    #1;
    chk("t5_cleared_rdy", {31'd0, mem_out_ready}, 32'd0);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    chk("t5_refetch_rd", {31'd0, mem_rd}, 32'd1);
    chk("t5_refetch_addr", mem_addr, 32'h0000_0000);
    ack_fill("t5", blk0, 0, 32'hD000_0000);

    // 6: spurious ack while idle leaves the array untouched
    expect_hit("t6_pre", 32'h0000_0008, 32'hD000_0002);
    mem_ack   = 1'b1;
    mem_rdata = junk;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    chk("t6_post_instr", instr, 32'hD000_0002);
    chk("t6_post_rdy", {31'd0, mem_out_ready}, 32'd1);
    expect_hit("t6_other", 32'h0000_000C, 32'hD000_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
